// File: rtl/alu_exec.sv
// Handshaked 32-bit ALU: single-cycle logic/arithmetic/compare ops and
// multi-cycle shifts that move the accumulator one bit per clock.
module alu_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        carry,
  output logic        ovf,
  output logic        illegal
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_acc;
  logic [3:0]  r_op;
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_carry;
  logic        r_ovf;
  logic        r_illegal;

  logic [32:0] w_add;
  logic [32:0] w_sub;
  logic [31:0] w_res;
  logic        w_carry;
  logic        w_ovf;
  logic        w_illegal;
  logic        w_shift;
  logic [31:0] w_acc_next;

  // SUB as a + ~b + 1 so bit 32 is the no-borrow flag (a >= b unsigned)
  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} + {1'b0, ~b} + 33'd1;

  always_comb begin
    w_res     = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    w_shift   = 1'b0;
    case (sel)
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_ADD: begin
        w_res   = w_add[31:0];
        w_carry = w_add[32];
        w_ovf   = (a[31] == b[31]) && (w_add[31] != a[31]);
      end
      OP_SUB: begin
        w_res   = w_sub[31:0];
        w_carry = w_sub[32];
        w_ovf   = (a[31] != b[31]) && (w_sub[31] != a[31]);
      end
      OP_SLL, OP_SRL, OP_SRA: begin
        w_res   = a;
        w_shift = (b[4:0] != 5'd0);
      end
      OP_SLT:  w_res = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: w_res = {31'd0, a < b};
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (r_op)
      OP_SLL:  w_acc_next = {r_acc[30:0], 1'b0};
      OP_SRL:  w_acc_next = {1'b0, r_acc[31:1]};
      default: w_acc_next = {r_acc[31], r_acc[31:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_op      <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_shift) begin
              r_acc   <= a;
              r_cnt   <= b[4:0];
              r_op    <= sel;
              r_state <= S_SHIFT;
            end else begin
              r_result  <= w_res;
              r_zero    <= (w_res == 32'd0);
              r_carry   <= w_carry;
              r_ovf     <= w_ovf;
              r_illegal <= w_illegal;
              r_state   <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_result  <= w_acc_next;
            r_zero    <= (w_acc_next == 32'd0);
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign ovf       = r_ovf;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: the driver queues hand-computed results,
// the monitor pops one per out_valid rise and checks result, flags and latency.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        carry;
  logic        ovf;
  logic        illegal;

  alu_exec dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .ovf(ovf), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z, c, o, il;
    int unsigned lat;  // posedges between acceptance and first out_valid sample
    int unsigned acc;
  } exp_t;

  exp_t        q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(logic [31:0] r, logic z, logic c, logic o, logic il,
                              int unsigned lat);
    exp_t e;
    e.res = r; e.z = z; e.c = c; e.o = o; e.il = il; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // Monitor
  logic prev_valid = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      chk("ready_valid_exclusive", {31'd0, in_ready & out_valid}, 32'd0);
      if (out_valid && !prev_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_output", result, 32'hxxxx_xxxx);
        end else begin
          held = q.pop_front();
          chk("result", result, held.res);
          chk("flags_zcoi", {28'd0, zero, carry, ovf, illegal},
              {28'd0, held.z, held.c, held.o, held.il});
          chk("latency", cyc - held.acc, held.lat);
        end
      end else if (out_valid && prev_valid) begin
        chk("hold_result", result, held.res);
        chk("hold_flags", {28'd0, zero, carry, ovf, illegal},
            {28'd0, held.z, held.c, held.o, held.il});
      end
      prev_valid = out_valid;
    end
  end

  task automatic issue(input logic [3:0] s, input logic [31:0] aa, input logic [31:0] bb,
                       input exp_t e, input bit push);
    int unsigned n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    sel = s; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) begin
      e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic wait_done(input int unsigned hold);
    int unsigned n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    for (int unsigned i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid = 1'b1; sel = 4'b0010; a = 32'hDEAD_BEEF; b = 32'h0000_0001;
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_ready_valid", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
  endtask

  task automatic run(input logic [3:0] s, input logic [31:0] aa, input logic [31:0] bb,
                     input exp_t e, input int unsigned hold);
    issue(s, aa, bb, e, 1'b1);
    wait_done(hold);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {28'd0, zero, carry, ovf, illegal}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //             sel      a             b              res          z  c  o  il lat
    run(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 1, 1, 0, 0, 0), 0);
    run(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 0, 0, 1, 0, 0), 0);
    run(4'b0110, 32'h8000_0000, 32'h0000_0001, mk(32'h7FFF_FFFF, 0, 1, 1, 0, 0), 0);
    run(4'b0110, 32'h0000_0005, 32'h0000_0005, mk(32'h0000_0000, 1, 1, 0, 0, 0), 0);
    run(4'b0110, 32'h0000_0001, 32'h0000_0002, mk(32'hFFFF_FFFF, 0, 0, 0, 0, 0), 0);
    run(4'b1000, 32'hFFFF_FFFF, 32'h0000_0000, mk(32'h0000_0001, 0, 0, 0, 0, 0), 0);
    run(4'b1001, 32'hFFFF_FFFF, 32'h0000_0000, mk(32'h0000_0000, 1, 0, 0, 0, 0), 0);
    run(4'b1000, 32'h0000_0001, 32'hFFFF_FFFF, mk(32'h0000_0000, 1, 0, 0, 0, 0), 0);
    run(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, mk(32'h00F0_00F0, 0, 0, 0, 0, 0), 0);
    run(4'b0001, 32'hF000_0000, 32'h0000_000F, mk(32'hF000_000F, 0, 0, 0, 0, 0), 0);
    run(4'b0011, 32'hA5A5_A5A5, 32'hFFFF_FFFF, mk(32'h5A5A_5A5A, 0, 0, 0, 0, 0), 0);
    run(4'b0111, 32'h8000_0000, 32'h0000_001F, mk(32'hFFFF_FFFF, 0, 0, 0, 0, 31), 0);
    run(4'b0100, 32'h1234_5678, 32'h0000_0000, mk(32'h1234_5678, 0, 0, 0, 0, 0), 0);
    run(4'b0100, 32'h1234_5678, 32'h0000_0020, mk(32'h1234_5678, 0, 0, 0, 0, 0), 0);
    run(4'b0100, 32'h1234_5678, 32'h0000_0004, mk(32'h2345_6780, 0, 0, 0, 0, 4), 0);
    run(4'b0101, 32'h8000_0000, 32'h0000_0001, mk(32'h4000_0000, 0, 0, 0, 0, 1), 0);
    run(4'b0111, 32'h8000_0000, 32'h0000_0004, mk(32'hF800_0000, 0, 0, 0, 0, 4), 0);
    run(4'b0111, 32'h4000_0000, 32'h0000_0002, mk(32'h1000_0000, 0, 0, 0, 0, 2), 0);
    run(4'b0101, 32'h0000_0001, 32'h0000_0001, mk(32'h0000_0000, 1, 0, 0, 0, 1), 0);
    run(4'b1010, 32'h1234_5678, 32'h0000_0001, mk(32'h0000_0000, 1, 0, 0, 1, 0), 0);
    // Held DONE with competing requests on the input
    run(4'b0011, 32'h0000_FFFF, 32'h00FF_00FF, mk(32'h00FF_FF00, 0, 0, 0, 0, 0), 5);
    run(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h0000_0000, 1, 0, 0, 1, 0), 0);

    // SRL by 20 aborted by reset on the 5th shift edge
    issue(4'b0101, 32'hF0F0_0000, 32'h0000_0014, mk('0, 0, 0, 0, 0, 0), 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ctl", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    chk("abort_result", result, 32'd0);
    chk("abort_flags", {28'd0, zero, carry, ovf, illegal}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort_no_valid", {31'd0, out_valid}, 32'd0);

    run(4'b0010, 32'h0000_0003, 32'h0000_0004, mk(32'h0000_0007, 0, 0, 0, 0, 0), 0);
    @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
